arcade_ce_gen: RTL

//  Multi-channel fractional clock-enable generator for arcade cores on clk_sys.

---
 rtl/arcade_ce_pkg.sv | 16 +
 rtl/arcade_ce_chan.sv | 74 +++++++
 rtl/arcade_ce_gen.sv | 53 +++++
 3 files changed

// File: rtl/arcade_ce_pkg.sv
// Shared widths, config payload type and helpers for the arcade clock-enable generator.
package arcade_ce_pkg;

    localparam int unsigned CE_ACC_W = 16;

    typedef struct packed {
        logic [CE_ACC_W-1:0] num;
        logic [CE_ACC_W-1:0] den;
    } ce_cfg_t;

    // Channel-select width; a single channel still needs a one-bit index.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arcade_ce_chan.sv
// One fractional clock-enable channel: phase accumulator stepping by num and
// wrapping at den, with runtime config, pause and resync.
module arcade_ce_chan #(
    parameter int unsigned      ACC_W   = 16,
    parameter logic [ACC_W-1:0] NUM_RST = ACC_W'(1),
    parameter logic [ACC_W-1:0] DEN_RST = ACC_W'(4)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pause,
    input  logic             resync,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_num,
    input  logic [ACC_W-1:0] wr_den,
    output logic             ce,
    output logic             phase_zero
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic             ce_q, ce_d;
    logic             pz_q, pz_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        acc_d = acc_q;
        num_d = num_q;
        den_d = den_q;
        ce_d  = 1'b0;
        sum   = {1'b0, acc_q} + {1'b0, num_q};
        if (resync || wr) begin
            // resync and a config write may coincide; both clear the phase
            acc_d = '0;
            if (wr) begin
                num_d = wr_num;
                den_d = wr_den;
            end
        end else if (pause) begin
            acc_d = acc_q;
        end else if ((den_q == '0) || (num_q == '0)) begin
            acc_d = '0;
        end else if (num_q >= den_q) begin
            acc_d = '0;
            ce_d  = 1'b1;
        end else if (sum >= {1'b0, den_q}) begin
            acc_d = ACC_W'(sum - {1'b0, den_q});
            ce_d  = 1'b1;
        end else begin
            acc_d = ACC_W'(sum);
        end
        pz_d = (acc_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            num_q <= NUM_RST;
            den_q <= DEN_RST;
            ce_q  <= 1'b0;
            pz_q  <= 1'b1;
        end else begin
            acc_q <= acc_d;
            num_q <= num_d;
            den_q <= den_d;
            ce_q  <= ce_d;
            pz_q  <= pz_d;
        end
    end

    assign ce         = ce_q;
    assign phase_zero = pz_q;

endmodule

// File: rtl/arcade_ce_gen.sv
// Multi-channel fractional clock-enable generator: NCH accumulators producing
// ce at clk_sys*num/den, with global pause, resync and per-channel reprogramming.
module arcade_ce_gen
    import arcade_ce_pkg::*;
#(
    parameter int unsigned NCH   = 3,
    parameter int unsigned ACC_W = CE_ACC_W,
    parameter logic [NCH*ACC_W-1:0] NUM_INIT = {NCH{ACC_W'(1)}},
    parameter logic [NCH*ACC_W-1:0] DEN_INIT = {ACC_W'(13), ACC_W'(6), ACC_W'(4)}
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  pause,
    input  logic                  resync,
    input  logic                  cfg_wr,
    input  logic [ch_w(NCH)-1:0]  cfg_ch,
    input  logic [ACC_W-1:0]      cfg_num,
    input  logic [ACC_W-1:0]      cfg_den,
    output logic [NCH-1:0]        ce,
    output logic [NCH-1:0]        phase_zero
);

    localparam int unsigned CH_W = ch_w(NCH);

    logic [NCH-1:0] wr_sel_c;

    // Indices at or above NCH match no channel, so such writes are dropped.
    always_comb begin
        wr_sel_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr_sel_c[i] = cfg_wr && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        arcade_ce_chan #(
            .ACC_W   (ACC_W),
            .NUM_RST (NUM_INIT[i*ACC_W +: ACC_W]),
            .DEN_RST (DEN_INIT[i*ACC_W +: ACC_W])
        ) u_chan (
            .clk        (clk_sys),
            .rst_n      (reset_n),
            .pause      (pause),
            .resync     (resync),
            .wr         (wr_sel_c[i]),
            .wr_num     (cfg_num),
            .wr_den     (cfg_den),
            .ce         (ce[i]),
            .phase_zero (phase_zero[i])
        );
    end

endmodule
